mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//   Sequences one dot-product pass of a neuron: operand selector -> multiplier -> accumulator -> output register.
//   On start: clears accumulator and selector pointer, then steps the selector through N input/weight pairs (inc/idx).
//   Drives accumulate-enable aligned to the multiplier pipeline, then loads the result and pulses done.
//   Sits between the layer-level scheduler (start/done) and one neuron datapath.
// PARAMETERS
//   N         2                   number of input/weight pairs per pass (N >= 1)
//   PIPE_LAT  1                   cycles from inc to valid product at accumulator input (PIPE_LAT >= 1)
//   IDX_W     (N>1)?$clog2(N):1   width of idx (localparam, derived)
// PORTS
//   clk      in   1      clock, all state updates on posedge
//   rst      in   1      asynchronous, active-high reset
//   start    in   1      request a pass; sampled only in IDLE or DONE
//   abort    in   1      synchronous cancel of a pass in progress
//   sel_rst  out  1      clear operand-selector pointer to element 0
//   inc      out  1      selector step: present element idx this cycle
//   idx      out  IDX_W  index of element being selected (valid while inc=1)
//   acc_clr  out  1      clear accumulator
//   acc_en   out  1      add current product into accumulator
//   out_ld   out  1      load accumulator into neuron output register
//   busy     out  1      high from CLR through DONE inclusive
//   done     out  1      one-cycle pulse, pass complete
// BEHAVIOUR
//   - All outputs registered (Moore); on rst: state=IDLE, idx=0, all outputs 0, delay line cleared.
//   - States: IDLE, CLR, FEED, DRAIN, DONE.
//   - IDLE: start=1 -> CLR. start=0 -> stay.
//   - CLR (1 cycle): acc_clr=1, sel_rst=1, busy=1 -> FEED.
//   - FEED (N cycles): inc=1, idx=0,1..N-1; after idx=N-1 -> DRAIN; idx returns to 0, never exceeds N-1.
//   - acc_en = inc delayed by PIPE_LAT cycles (shift register), giving exactly N acc_en pulses per pass.
//   - DRAIN (PIPE_LAT cycles): inc=0, acc_en still draining; after last acc_en cycle -> DONE.
//   - DONE (1 cycle): out_ld=1, done=1, busy=1.
//       start=1 -> CLR (back-to-back pass).
//       start=0 -> IDLE.
//   - Latency: start sampled at edge k -> acc_clr in cycle k+1, first inc k+2,
//     done in cycle k+2+N+PIPE_LAT; period back-to-back = N+PIPE_LAT+2.
//   - start while in CLR/FEED/DRAIN: ignored, no queueing.
//   - abort=1 in CLR/FEED/DRAIN -> IDLE next edge; delay line flushed, no acc_en/out_ld/done emitted.
//   - abort in IDLE or DONE: no effect; in DONE, done still pulses.
//   - abort and start together: abort wins.
//   - Async rst mid-pass: immediate return to IDLE outputs; no done.
//   - N=1: FEED lasts one cycle with idx=0.
// STRUCTURE
//   - Shared package nn_ctrl_pkg: state enum (IDLE,CLR,FEED,DRAIN,DONE), state width, idx-width function.
//   - Sub-module pulse_delay #(LAT): LAT-stage 1-bit shift register, async clear and sync flush; generates acc_en.
//   - Remainder: FSM, idx counter, DRAIN counter (width $clog2(PIPE_LAT+1)).
// TESTING
//   1. N=2, PIPE_LAT=1, start pulse at cycle 0 -> acc_clr@1, inc@2,3 (idx 0,1), acc_en@3,4, out_ld/done@5, busy 1..5.
//   2. N=4, PIPE_LAT=3, start held high -> done every 9 cycles; exactly 4 acc_en per pass; acc_clr the cycle after each done.
//   3. N=2 start re-pulsed during FEED -> ignored; single done at cycle 5; no second pass.
//   4. N=4, abort in FEED at idx=2 -> IDLE next cycle; acc_en, out_ld, done stay 0; fresh start then runs full pass.
//   5. rst asserted asynchronously mid-DRAIN (between edges) -> all outputs 0 immediately; idle after release.
//   6. N=1, PIPE_LAT=1 -> single inc idx=0 @2, acc_en@3, done@4; abort+start same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the neuron MAC sequencer: pass states and the
// width helper used to size the element index.
package nn_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // A single-element pass still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Scheduler-side handshake and datapath control strobes of one MAC sequencer.
interface mac_sequencer_if #(
  parameter int N = 2
);
  localparam int IDX_W = nn_ctrl_pkg::idx_w(N);

  logic             start;
  logic             abort;
  logic             sel_rst;
  logic             inc;
  logic [IDX_W-1:0] idx;
  logic             acc_clr;
  logic             acc_en;
  logic             out_ld;
  logic             busy;
  logic             done;

  modport master (
    output start, abort,
    input  sel_rst, inc, idx, acc_clr, acc_en, out_ld, busy, done
  );

  modport slave (
    input  start, abort,
    output sel_rst, inc, idx, acc_clr, acc_en, out_ld, busy, done
  );

endinterface

// File: rtl/mac_sequencer_pulse_delay.sv
// LAT-stage single-bit delay line with async clear and synchronous flush;
// turns the selector step strobe into the accumulate enable.
module pulse_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr_q, sr_d;

  generate
    if (LAT == 1) begin : g_one
      always_comb begin
        sr_d = flush ? 1'b0 : din;
      end
    end else begin : g_multi
      always_comb begin
        sr_d = flush ? '0 : {sr_q[LAT-2:0], din};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign dout = sr_q[LAT-1];

endmodule

// File: rtl/mac_sequencer.sv
// One dot-product pass controller: clear, feed N operand pairs, drain the
// multiplier pipeline, then load the result and pulse done.
module mac_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N        = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mac_sequencer_if.slave   bus
);

  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  logic             sel_rst_q, sel_rst_d;
  logic             inc_q, inc_d;
  logic             acc_clr_q, acc_clr_d;
  logic             out_ld_q, out_ld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             flush;
  logic             acc_en;

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start && !bus.abort) state_d = S_CLR;
      S_CLR:   state_d = S_FEED;
      S_FEED:  if (idx_q == IDX_W'(N - 1)) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == CNT_W'(PIPE_LAT - 1)) state_d = S_DONE;
      S_DONE:  state_d = (bus.start && !bus.abort) ? S_CLR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && (state_q inside {S_CLR, S_FEED, S_DRAIN})) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered so every strobe
  // comes straight from a flop while keeping Moore timing.
  always_comb begin
    idx_d     = '0;
    drain_d   = '0;
    if (state_d == S_FEED && state_q == S_FEED)   idx_d   = idx_q + IDX_W'(1);
    if (state_d == S_DRAIN && state_q == S_DRAIN) drain_d = drain_q + CNT_W'(1);
    sel_rst_d = (state_d == S_CLR);
    acc_clr_d = (state_d == S_CLR);
    inc_d     = (state_d == S_FEED);
    out_ld_d  = (state_d == S_DONE);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      drain_q   <= '0;
      sel_rst_q <= 1'b0;
      inc_q     <= 1'b0;
      acc_clr_q <= 1'b0;
      out_ld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      sel_rst_q <= sel_rst_d;
      inc_q     <= inc_d;
      acc_clr_q <= acc_clr_d;
      out_ld_q  <= out_ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  pulse_delay #(.LAT(PIPE_LAT)) u_acc_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   (inc_q),
    .dout  (acc_en)
  );

  assign bus.sel_rst = sel_rst_q;
  assign bus.inc     = inc_q;
  assign bus.idx     = idx_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.acc_en  = acc_en;
  assign bus.out_ld  = out_ld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
